// File: rtl/riscv_core_dpath_vec_reduce.sv
// riscv_core_dpath_vec_reduce: folds active 32-bit vector elements into one scalar, one element per cycle
// Ports: clk/reset (sync, active-high); in_val/in_rdy/in_vec/in_vm/in_vl/in_fn accept an operation;
// out_val/out_rdy/out_result/out_count hand back the reduced scalar and the number of active elements folded.
module riscv_core_dpath_vec_reduce #(
  parameter int NLANES = 8,
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [NLANES*W-1:0]   in_vec,
  input  logic [NLANES-1:0]     in_vm,
  input  logic [3:0]            in_vl,
  input  logic [2:0]            in_fn,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [W-1:0]          out_result,
  output logic [3:0]            out_count
);
  localparam int LW = NLANES > 1 ? $clog2(NLANES) : 1;
  localparam logic [3:0] NL = 4'(NLANES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [NLANES-1:0][W-1:0] vec_q, vec_d;
  logic [NLANES-1:0] vm_q, vm_d;
  logic [2:0] fn_q, fn_d;
  logic [3:0] vl_q, vl_d, idx_q, idx_d, cnt_q, cnt_d, vl_eff;
  logic [W-1:0] acc_q, acc_d, elem, ident, red;
  logic lt;
  assign vl_eff = in_vl > NL ? NL : in_vl;
  assign elem = vec_q[idx_q[LW-1:0]];
  assign lt = $signed(elem) < $signed(acc_q);
  assign ident = in_fn == 3'd1 ? '1 :
                 in_fn == 3'd4 ? {1'b0, {(W-1){1'b1}}} :
                 in_fn == 3'd5 ? {1'b1, {(W-1){1'b0}}} : '0;
  // reserved functions fall through to acc_q, which stays at its identity 0
  assign red = fn_q == 3'd0 ? acc_q + elem :
               fn_q == 3'd1 ? acc_q & elem :
               fn_q == 3'd2 ? acc_q | elem :
               fn_q == 3'd3 ? acc_q ^ elem :
               fn_q == 3'd4 ? (lt ? elem : acc_q) :
               fn_q == 3'd5 ? (lt ? acc_q : elem) : acc_q;
  // outputs are forced quiet during the reset cycle itself, independent of the held state
  assign in_rdy = state_q == IDLE && !reset;
  assign out_val = state_q == DONE && !reset;
  assign out_result = reset ? '0 : acc_q;
  assign out_count = reset ? '0 : cnt_q;
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    vm_d = vm_q;
    fn_d = fn_q;
    vl_d = vl_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    case (state_q)
      IDLE: if (in_val) begin
        vec_d = in_vec;
        vm_d = in_vm;
        fn_d = in_fn;
        vl_d = vl_eff;
        acc_d = ident;
        idx_d = '0;
        cnt_d = '0;
        state_d = vl_eff == '0 ? DONE : RUN;
      end
      RUN: begin
        acc_d = vm_q[idx_q[LW-1:0]] ? red : acc_q;
        cnt_d = vm_q[idx_q[LW-1:0]] ? cnt_q + 4'd1 : cnt_q;
        idx_d = idx_q + 4'd1;
        state_d = idx_q == vl_q - 4'd1 ? DONE : RUN;
      end
      DONE: state_d = out_rdy ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q <= '0;
      vm_q <= '0;
      fn_q <= '0;
      vl_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      vm_q <= vm_d;
      fn_q <= fn_d;
      vl_q <= vl_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: tb/tb_riscv_core_dpath_vec_reduce.sv
// tb_riscv_core_dpath_vec_reduce: randomized and directed checks of the vector reduction unit against a list-based model
module tb_riscv_core_dpath_vec_reduce;
  logic clk = 0;
  logic reset = 1;
  logic in_val = 0;
  logic in_rdy;
  logic [255:0] in_vec = '0;
  logic [7:0] in_vm = '0;
  logic [3:0] in_vl = '0;
  logic [2:0] in_fn = '0;
  logic out_val;
  logic out_rdy = 0;
  logic [31:0] out_result;
  logic [3:0] out_count;
  int checks = 0;
  int failures = 0;
  riscv_core_dpath_vec_reduce #(.NLANES(8), .W(32)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_vec(in_vec),
    .in_vm(in_vm), .in_vl(in_vl), .in_fn(in_fn), .out_val(out_val), .out_rdy(out_rdy),
    .out_result(out_result), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  function automatic void model(input logic [255:0] v, input logic [7:0] m, input logic [3:0] vl,
                                input logic [2:0] fn, output logic [31:0] r, output logic [3:0] c);
    int n;
    int q[$];
    int acc;
    n = vl > 8 ? 8 : int'(vl);
    for (int i = 0; i < n; i++) if (m[i]) q.push_back(int'(v[i*32 +: 32]));
    c = 4'(q.size());
    case (fn)
      3'd0: begin acc = 0; foreach (q[i]) acc = acc + q[i]; end
      3'd1: begin acc = -1; foreach (q[i]) acc = acc & q[i]; end
      3'd2: begin acc = 0; foreach (q[i]) acc = acc | q[i]; end
      3'd3: begin acc = 0; foreach (q[i]) acc = acc ^ q[i]; end
      3'd4: begin acc = 32'h7FFFFFFF; foreach (q[i]) if (q[i] < acc) acc = q[i]; end
      3'd5: begin acc = int'(32'h80000000); foreach (q[i]) if (q[i] > acc) acc = q[i]; end
      default: acc = 0;
    endcase
    r = 32'(acc);
  endfunction
  task automatic run_op(input logic [255:0] v, input logic [7:0] m, input logic [3:0] vl,
                        input logic [2:0] fn, input int hold);
    logic [31:0] er;
    logic [3:0] ec;
    int lat;
    int w;
    int vle;
    model(v, m, vl, fn, er, ec);
    vle = vl > 8 ? 8 : int'(vl);
    w = 0;
    while (!in_rdy && w < 50) begin tick; w++; end
    chk("in_rdy_before_accept", 32'(in_rdy), 32'd1);
    in_vec = v; in_vm = m; in_vl = vl; in_fn = fn; in_val = 1; out_rdy = 0;
    tick;
    in_val = 0; in_vec = rand_vec(); in_vm = 8'($urandom); in_vl = 4'($urandom); in_fn = 3'($urandom);
    lat = 0;
    while (!out_val && lat < 20) begin
      chk("in_rdy_busy", 32'(in_rdy), 32'd0);
      tick;
      lat++;
    end
    chk("latency", 32'(lat), 32'(vle));
    chk("result", out_result, er);
    chk("count", 32'(out_count), 32'(ec));
    repeat (hold) begin
      in_vec = rand_vec(); in_val = 1'($urandom);
      tick;
      chk("hold_val", 32'(out_val), 32'd1);
      chk("hold_result", out_result, er);
      chk("hold_count", 32'(out_count), 32'(ec));
      chk("hold_in_rdy", 32'(in_rdy), 32'd0);
    end
    in_val = 0; out_rdy = 1;
    tick;
    out_rdy = 0;
    chk("val_after_take", 32'(out_val), 32'd0);
    chk("in_rdy_after_take", 32'(in_rdy), 32'd1);
  endtask
  initial begin
    logic [255:0] v;
    tick;
    chk("reset_in_rdy", 32'(in_rdy), 32'd0);
    chk("reset_out_val", 32'(out_val), 32'd0);
    chk("reset_result", out_result, 32'd0);
    chk("reset_count", 32'(out_count), 32'd0);
    tick;
    reset = 0;
    #1;
    chk("idle_in_rdy", 32'(in_rdy), 32'd1);
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(i + 1);
    run_op(v, 8'hFF, 4'd8, 3'd0, 0);
    v = rand_vec();
    v[31:0] = 32'd5; v[63:32] = -32'sd3; v[95:64] = 32'd7; v[127:96] = -32'sd9;
    run_op(v, 8'b0000_0111, 4'd3, 3'd4, 1);
    run_op(rand_vec(), 8'hFF, 4'd0, 3'd1, 0);
    run_op(rand_vec(), 8'h00, 4'd8, 3'd5, 0);
    v = {8{32'h80000000}};
    run_op(v, 8'hFF, 4'd15, 3'd0, 0);
    run_op(rand_vec(), 8'hA5, 4'd6, 3'd2, 5);
    in_vec = rand_vec(); in_vm = 8'hFF; in_vl = 4'd8; in_fn = 3'd0; in_val = 1;
    tick;
    in_val = 0;
    tick;
    tick;
    reset = 1;
    #1;
    chk("midrun_reset_in_rdy", 32'(in_rdy), 32'd0);
    chk("midrun_reset_out_val", 32'(out_val), 32'd0);
    chk("midrun_reset_result", out_result, 32'd0);
    chk("midrun_reset_count", 32'(out_count), 32'd0);
    tick;
    reset = 0;
    #1;
    chk("post_reset_in_rdy", 32'(in_rdy), 32'd1);
    chk("post_reset_out_val", 32'(out_val), 32'd0);
    v = rand_vec();
    v[31:0] = 32'hF0; v[63:32] = 32'h0F;
    run_op(v, 8'h03, 4'd2, 3'd3, 0);
    for (int k = 0; k < 40; k++)
      run_op(rand_vec(), 8'($urandom), 4'($urandom), 3'($urandom), int'($urandom_range(0, 2)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
